// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe -- two-stage pipelined ALU with a persistent carry register.
//
// This ALU supports the 12 base operations: arithmetic, logic, shifts and
// rotates. It adds ADC, SBC and CMP so that multi-word arithmetic can be
// chained through carry_q. A valid/ready handshake is used on both sides.
//
// Stage 1 registers the operands and the opcode. The ALU result is computed
// combinationally from stage 1. Stage 2 registers the result and the flags and
// drives the outputs. carry_q takes the carry of every op that moves from
// stage 1 to stage 2, except the reserved opcode. Back-to-back ADC/SBC ops
// therefore chain without a bubble.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode present
//   in_ready   pipe accepts operands this cycle
//   A, B       WIDTH-bit operands
//   opcode     4-bit operation select
//   out_valid  result/flags valid
//   out_ready  consumer takes the result this cycle
//   result     registered WIDTH-bit result
//   zero       result == 0
//   carry      carry / borrow / shifted-out bit
//   overflow   signed overflow
//   sign       sign of the (arithmetic) result
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             sign
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_ADC = 4'b1100;
    localparam logic [3:0] OP_SBC = 4'b1101;
    localparam logic [3:0] OP_CMP = 4'b1110;
    localparam logic [3:0] OP_RSV = 4'b1111;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             c;
        logic             v;
        logic             s;
    } alu_out_t;

    // All add/subtract variants share one (WIDTH+1)-bit adder. On subtracts,
    // bit WIDTH of the wrapped difference is the borrow. CMP keeps A as its
    // result but reports the flags of A-B. Zero always follows the result.
    function automatic alu_out_t alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [3:0]       op,
        input logic             cin
    );
        alu_out_t         o;
        logic [WIDTH-1:0] opnd;
        logic [WIDTH:0]   ext;
        logic             is_arith;
        logic             is_sub;
        logic             use_cin;
        o        = '0;
        opnd     = b;
        is_arith = 1'b0;
        is_sub   = 1'b0;
        use_cin  = 1'b0;
        case (op)
            OP_ADD: is_arith = 1'b1;
            OP_SUB: begin is_arith = 1'b1; is_sub = 1'b1; end
            OP_INC: begin is_arith = 1'b1; opnd = WIDTH'(1); end
            OP_DEC: begin is_arith = 1'b1; is_sub = 1'b1; opnd = WIDTH'(1); end
            OP_ADC: begin is_arith = 1'b1; use_cin = 1'b1; end
            OP_SBC: begin is_arith = 1'b1; is_sub = 1'b1; use_cin = 1'b1; end
            OP_CMP: begin is_arith = 1'b1; is_sub = 1'b1; end
            default: ;
        endcase

        if (is_sub)
            ext = {1'b0, a} - {1'b0, opnd} - {{WIDTH{1'b0}}, use_cin & cin};
        else
            ext = {1'b0, a} + {1'b0, opnd} + {{WIDTH{1'b0}}, use_cin & cin};

        case (op)
            OP_AND: o.res = a & b;
            OP_OR:  o.res = a | b;
            OP_XOR: o.res = a ^ b;
            OP_NOT: o.res = ~a;
            OP_SHL: begin o.res = {a[WIDTH-2:0], 1'b0};      o.c = a[WIDTH-1]; end
            OP_SHR: begin o.res = {1'b0, a[WIDTH-1:1]};      o.c = a[0];       end
            OP_ROL: begin o.res = {a[WIDTH-2:0], a[WIDTH-1]}; o.c = a[WIDTH-1]; end
            OP_ROR: begin o.res = {a[0], a[WIDTH-1:1]};      o.c = a[0];       end
            OP_CMP: o.res = a;
            OP_RSV: o.res = '0;
            default: o.res = ext[WIDTH-1:0];
        endcase

        if (is_arith) begin
            o.c = ext[WIDTH];
            if (is_sub)
                o.v = (a[WIDTH-1] != opnd[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
            else
                o.v = (a[WIDTH-1] == opnd[WIDTH-1]) && (ext[WIDTH-1] != a[WIDTH-1]);
        end

        o.z = (o.res == '0);
        o.s = is_arith ? ext[WIDTH-1] : o.res[WIDTH-1];
        return o;
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [3:0]       op_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] res_p2;
    logic             z_p2;
    logic             c_p2;
    logic             v_p2;
    logic             s_p2;

    logic             carry_q;
    logic             s1_adv;
    logic             s2_adv;
    alu_out_t         alu_p1;

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_adv;
    assign in_ready = !vld_p1 || s2_adv;

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_p1  <= A;
            b_p1  <= B;
            op_p1 <= opcode;
        end
    end

    assign alu_p1 = alu_eval(a_p1, b_p1, op_p1, carry_q);

    // ---- stage 2: result and flag registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            res_p2  <= '0;
            z_p2    <= 1'b0;
            c_p2    <= 1'b0;
            v_p2    <= 1'b0;
            s_p2    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (s2_adv)
                vld_p2 <= vld_p1;
            if (s1_adv) begin
                res_p2 <= alu_p1.res;
                z_p2   <= alu_p1.z;
                c_p2   <= alu_p1.c;
                v_p2   <= alu_p1.v;
                s_p2   <= alu_p1.s;
                // The reserved opcode must not disturb a carry chain in progress.
                if (op_p1 != OP_RSV)
                    carry_q <= alu_p1.c;
            end
        end
    end

    assign out_valid = vld_p2;
    assign result    = res_p2;
    assign zero      = z_p2;
    assign carry     = c_p2;
    assign overflow  = v_p2;
    assign sign      = s_p2;

endmodule
